// File: rtl/cpu_run_ctrl.sv
// Run controller for the 8-bit CPU cores: sequences core reset release, gates
// execution through a clock enable, counts enabled cycles and ends the run on halt or budget.
module cpu_run_ctrl #(
  parameter int NUM_CORES    = 1,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 875,
  parameter int CNT_W        = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 MODE,
  input  logic                 STEP,
  input  logic [NUM_CORES-1:0] CORE_HALT,
  output logic [NUM_CORES-1:0] CORE_RESET,
  output logic                 CORE_CLK_EN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT,
  output logic [CNT_W-1:0]     CYCLE_COUNT
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_RST = 2'd1,
    RUN      = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [RCW-1:0]   rst_cnt, rst_cnt_nx;
  logic             mode_q, mode_nx;
  logic             step_q;
  logic             rst_nx, en_nx, busy_nx, done_nx, to_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             step_rise, all_halt;

  assign step_rise = STEP & ~step_q;
  assign all_halt  = &CORE_HALT;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      mode_q      <= 1'b0;
      step_q      <= 1'b0;
      CORE_RESET  <= '1;
      CORE_CLK_EN <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      TIMEOUT     <= 1'b0;
      CYCLE_COUNT <= '0;
    end else begin
      state       <= state_nx;
      rst_cnt     <= rst_cnt_nx;
      mode_q      <= mode_nx;
      step_q      <= STEP;
      CORE_RESET  <= {NUM_CORES{rst_nx}};
      CORE_CLK_EN <= en_nx;
      BUSY        <= busy_nx;
      DONE        <= done_nx;
      TIMEOUT     <= to_nx;
      CYCLE_COUNT <= cnt_nx;
    end
  end

  // Outputs are registered, so everything below computes the value for the next cycle.
  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    mode_nx    = mode_q;
    rst_nx     = CORE_RESET[0];
    en_nx      = 1'b0;
    done_nx    = DONE;
    to_nx      = TIMEOUT;
    cnt_nx     = CYCLE_COUNT;
    case (state)
      IDLE, FINISH: begin
        rst_nx = (state == IDLE);
        if (START) begin
          state_nx   = HOLD_RST;
          mode_nx    = MODE;
          rst_cnt_nx = '0;
          rst_nx     = 1'b1;
          en_nx      = 1'b1;
          done_nx    = 1'b0;
          to_nx      = 1'b0;
          cnt_nx     = '0;
        end
      end
      HOLD_RST: begin
        rst_nx = 1'b1;
        en_nx  = 1'b1;
        if (rst_cnt == RST_LAST) begin
          state_nx = RUN;
          rst_nx   = 1'b0;
          en_nx    = mode_q ? step_rise : 1'b1;
        end else begin
          rst_cnt_nx = rst_cnt + 1'b1;
        end
      end
      RUN: begin
        rst_nx = 1'b0;
        if (CORE_CLK_EN) cnt_nx = CYCLE_COUNT + 1'b1;
        // Halt takes priority over the budget; any pending step pulse dies on exit.
        if (all_halt) begin
          state_nx = FINISH;
          done_nx  = 1'b1;
        end else if (CORE_CLK_EN && (CYCLE_COUNT == CNT_LAST)) begin
          state_nx = FINISH;
          to_nx    = 1'b1;
        end else begin
          en_nx = mode_q ? step_rise : 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        rst_nx   = 1'b1;
      end
    endcase
    busy_nx = (state_nx == HOLD_RST) || (state_nx == RUN);
  end

  a_cnt_bound: assert property (@(posedge CLOCK) disable iff (RESET)
    CYCLE_COUNT <= CNT_W'(MAX_CYCLES));
  a_flags_excl: assert property (@(posedge CLOCK) disable iff (RESET)
    !(DONE && TIMEOUT));

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized traffic,
// all compared each cycle against a run-level behavioural model.
module tb_cpu_run_ctrl;
  localparam int NC = 2, RC = 2, MC = 20, CW = 8;

  logic          CLOCK = 1'b0;
  logic          RESET, START, MODE, STEP;
  logic [NC-1:0] CORE_HALT;
  logic [NC-1:0] CORE_RESET;
  logic          CORE_CLK_EN, BUSY, DONE, TIMEOUT;
  logic [CW-1:0] CYCLE_COUNT;

  cpu_run_ctrl #(.NUM_CORES(NC), .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CNT_W(CW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .MODE(MODE), .STEP(STEP),
    .CORE_HALT(CORE_HALT), .CORE_RESET(CORE_RESET), .CORE_CLK_EN(CORE_CLK_EN),
    .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .CYCLE_COUNT(CYCLE_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a run is "active" from START acceptance until it ends; the first
  // hold_left active cycles keep the cores in reset.
  bit m_active, m_rst, m_en, m_done, m_to, m_mode, m_prev;
  int m_hold_left, m_cnt;

  task automatic model_step();
    bit rise;
    if (RESET) begin
      m_active = 0; m_rst = 1; m_en = 0; m_done = 0; m_to = 0;
      m_mode = 0; m_prev = 0; m_cnt = 0; m_hold_left = 0;
      return;
    end
    rise = STEP && !m_prev;
    m_prev = STEP;
    if (!m_active) begin
      m_en = 0;
      if (START) begin
        m_active = 1; m_hold_left = RC; m_mode = MODE;
        m_cnt = 0; m_done = 0; m_to = 0; m_rst = 1; m_en = 1;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_rst = 0;
        m_en  = m_mode ? rise : 1'b1;
      end else m_en = 1;
    end else begin
      if (m_en) m_cnt++;
      if (CORE_HALT == '1) begin
        m_done = 1; m_active = 0; m_en = 0;
      end else if (m_cnt == MC) begin
        m_to = 1; m_active = 0; m_en = 0;
      end else m_en = m_mode ? rise : 1'b1;
    end
  endtask

  task automatic check_all();
    chk("core_reset", 32'(CORE_RESET), 32'({NC{m_rst}}));
    chk("clk_en", 32'(CORE_CLK_EN), 32'(m_en));
    chk("busy", 32'(BUSY), 32'(m_active));
    chk("done", 32'(DONE), 32'(m_done));
    chk("timeout", 32'(TIMEOUT), 32'(m_to));
    chk("cycle_count", 32'(CYCLE_COUNT), 32'(m_cnt));
  endtask

  task automatic cycle();
    @(posedge CLOCK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic start_run(input bit mode);
    START = 1; MODE = mode; cycle();
    START = 0; MODE = ~mode;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (BUSY && n < budget) begin cycle(); n++; end
    chk({tag, "_bound"}, 32'(BUSY), 32'(0));
  endtask

  int en_n, rst_n;

  initial begin
    RESET = 1; START = 0; MODE = 0; STEP = 0; CORE_HALT = '0;
    cycle(); cycle();
    chk("rst_core_reset", 32'(CORE_RESET), 32'h3);
    chk("rst_cycle_count", 32'(CYCLE_COUNT), 32'h0);
    RESET = 0; cycle();

    // 1: free run to budget
    start_run(0);
    en_n = 32'(CORE_CLK_EN); rst_n = (CORE_RESET == 2'b11) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      en_n += 32'(CORE_CLK_EN);
      if (CORE_RESET == 2'b11) rst_n++;
    end
    chk("s1_en_cycles", en_n, 22);
    chk("s1_rst_cycles", rst_n, 2);
    chk("s1_timeout", 32'(TIMEOUT), 1);
    chk("s1_done", 32'(DONE), 0);
    chk("s1_count", 32'(CYCLE_COUNT), MC);
    chk("s1_busy", 32'(BUSY), 0);

    // 2: staged halt
    start_run(0);
    for (int i = 0; i < 40 && BUSY; i++) begin
      CORE_HALT = (m_cnt >= 9) ? 2'b11 : (m_cnt >= 5) ? 2'b01 : 2'b00;
      cycle();
    end
    chk("s2_done", 32'(DONE), 1);
    chk("s2_count", 32'(CYCLE_COUNT), 10);
    chk("s2_timeout", 32'(TIMEOUT), 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("s2_clk_en", 32'(CORE_CLK_EN), 0);
    chk("s2_core_reset", 32'(CORE_RESET), 0);
    CORE_HALT = '0;

    // 3: single step, one STEP held for 4 cycles
    start_run(1);
    for (int i = 0; i < 4; i++) cycle();
    en_n = 0;
    for (int p = 0; p < 3; p++) begin
      STEP = 1;
      for (int i = 0; i < ((p == 1) ? 4 : 1); i++) begin cycle(); en_n += 32'(CORE_CLK_EN); end
      STEP = 0;
      for (int i = 0; i < 3; i++) begin cycle(); en_n += 32'(CORE_CLK_EN); end
    end
    chk("s3_pulses", en_n, 3);
    chk("s3_count", 32'(CYCLE_COUNT), 3);
    chk("s3_busy", 32'(BUSY), 1);
    CORE_HALT = 2'b11; cycle(); CORE_HALT = '0;
    chk("s3_done", 32'(DONE), 1);

    // 4: halt coincides with the final budget cycle
    start_run(0);
    for (int i = 0; i < 40 && BUSY; i++) begin
      CORE_HALT = (m_cnt == MC - 1) ? 2'b11 : 2'b00;
      cycle();
    end
    CORE_HALT = '0;
    chk("s4_done", 32'(DONE), 1);
    chk("s4_timeout", 32'(TIMEOUT), 0);
    chk("s4_count", 32'(CYCLE_COUNT), MC);

    // 5: restart from FINISH, START during RUN ignored
    start_run(0);
    chk("s5_done_clr", 32'(DONE), 0);
    chk("s5_count_clr", 32'(CYCLE_COUNT), 0);
    chk("s5_core_reset", 32'(CORE_RESET), 32'h3);
    for (int i = 0; i < 5; i++) cycle();
    START = 1; cycle(); cycle(); START = 0;
    wait_idle(40, "s5");
    chk("s5_timeout", 32'(TIMEOUT), 1);

    // 6: reset mid-run
    start_run(0);
    for (int i = 0; i < 40 && m_cnt < 7; i++) cycle();
    chk("s6_pre_count", 32'(CYCLE_COUNT), 7);
    RESET = 1; cycle(); RESET = 0;
    chk("s6_core_reset", 32'(CORE_RESET), 32'h3);
    chk("s6_clk_en", 32'(CORE_CLK_EN), 0);
    chk("s6_count", 32'(CYCLE_COUNT), 0);
    chk("s6_busy", 32'(BUSY), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 199) == 0);
      START = ($urandom_range(0, 7) == 0);
      MODE  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) STEP = ~STEP;
      CORE_HALT = ($urandom_range(0, 23) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run controller for the 8-bit CPU cores, synthesizable onto the FPGA. It sequences per-core reset release and gates core execution through a clock enable. It runs the cores free-running or single-stepped, counts executed cycles, and ends the run when every core halts or a cycle budget expires. It sits between the board clock/reset and one or more CPU instances, so the start, run, stop and timeout sequence runs in hardware.

Parameters:
NUM_CORES, 1, number of CPU cores controlled (1..8)
RESET_CYCLES, 2, enabled cycles CORE_RESET is held after START (>=1)
MAX_CYCLES, 875, cycle budget before timeout (1..2^CNT_W-1)
CNT_W, 16, width of cycle counter

Ports:
CLOCK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high master reset
START  input  1  level; sampled high in IDLE or FINISH begins a run
MODE  input  1  0 = free-run, 1 = single-step; latched when START is accepted
STEP  input  1  single-step request; rising edge detected internally
CORE_HALT  input  NUM_CORES  per-core halted flag
CORE_RESET  output  NUM_CORES  per-core synchronous reset to CPUs, all bits equal
CORE_CLK_EN  output  1  clock enable to CPUs
BUSY  output  1  high in HOLD_RST and RUN
DONE  output  1  sticky: run ended because all cores halted
TIMEOUT  output  1  sticky: run ended on cycle budget
CYCLE_COUNT  output  CNT_W  enabled RUN cycles in current or last run

Behaviour:
- One clock domain. Reset is synchronous and active-high. The ports are named CLOCK and RESET.
- All outputs are registered.
- RESET=1 at an edge forces these values: state IDLE, CORE_RESET all 1, CORE_CLK_EN 0, BUSY 0, DONE 0, TIMEOUT 0, CYCLE_COUNT 0, step edge register 0, latched mode 0.
- RESET overrides every input in any state, including mid-run.
- IDLE:
  - CORE_RESET all 1, CORE_CLK_EN 0.
  - START=1 -> HOLD_RST. Latch MODE. Clear reset counter.
- HOLD_RST:
  - CORE_RESET all 1, CORE_CLK_EN 1, BUSY 1.
  - Counts RESET_CYCLES edges, then -> RUN.
  - CORE_RESET deasserts on the same edge that enters RUN.
- RUN, CORE_RESET all 0:
  - Free-run: CORE_CLK_EN=1 every cycle.
  - Single-step: CORE_CLK_EN is a one-cycle pulse on the cycle after a STEP 0->1 edge is detected. STEP held high produces exactly one pulse.
  - CYCLE_COUNT increments on each edge where state=RUN and CORE_CLK_EN=1.
- Exit from RUN (evaluated every RUN cycle):
  - All CORE_HALT bits 1 -> FINISH, DONE<=1.
  - Else, CYCLE_COUNT==MAX_CYCLES-1 while an enabled cycle occurs -> FINISH, TIMEOUT<=1, CYCLE_COUNT ends at MAX_CYCLES.
  - Halt and budget in the same cycle: DONE=1, TIMEOUT=0 (halt wins). The count still increments for that cycle.
  - A pending step pulse is discarded on exit.
- FINISH:
  - CORE_CLK_EN 0, CORE_RESET stays 0 so core state is preserved for inspection, BUSY 0.
  - DONE, TIMEOUT and CYCLE_COUNT hold.
  - START=1 -> HOLD_RST. Clears DONE, TIMEOUT and CYCLE_COUNT, re-latches MODE.
- START is ignored in HOLD_RST and RUN. MODE changes after latch are ignored.
- CORE_HALT is ignored outside RUN.
- CYCLE_COUNT never exceeds MAX_CYCLES. No wrap.
- Partial halt (some bits 0) does not end the run.

Test Plan:
All scenarios use NUM_CORES=2, RESET_CYCLES=2, MAX_CYCLES=20, CNT_W=8.
1. RESET 2 cycles, START pulse, MODE=0, CORE_HALT=00 -> CORE_RESET=11 for exactly 2 cycles after START, then 00. CORE_CLK_EN high 22 cycles. TIMEOUT=1, DONE=0, CYCLE_COUNT=20, BUSY falls.
2. Free-run, CORE_HALT=01 at count 5, 11 at count 9 -> DONE=1 with CYCLE_COUNT=10, TIMEOUT=0. CORE_CLK_EN 0 afterwards; CORE_RESET stays 00.
3. MODE=1, STEP pulsed 3 times (one held high 4 cycles) -> exactly 3 single-cycle CORE_CLK_EN pulses, CYCLE_COUNT=3, BUSY=1.
4. CORE_HALT=11 arriving on the same cycle CYCLE_COUNT goes 19->20 -> DONE=1, TIMEOUT=0, CYCLE_COUNT=20.
5. From FINISH with DONE=1, START again -> DONE/TIMEOUT/CYCLE_COUNT clear. CORE_RESET=11 for 2 cycles, new run proceeds. START asserted during RUN has no effect.
6. RESET asserted at CYCLE_COUNT=7 mid-run -> next edge: IDLE, CORE_RESET=11, CORE_CLK_EN=0, CYCLE_COUNT=0, all flags 0.
